// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI3 write arbiter in front of a shared HP port.
// One burst is owned at a time, from its AW handshake through its B handshake.
// Winner selection is round-robin (RR_EN=1) or fixed priority to port 0 (RR_EN=0).
// All payload and handshake paths are combinational muxes. The only added
// latency is the single cycle spent registering the grant in ST_IDLE.
module axi_wr_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input  logic        aclk,
    input  logic        rst_i,

    // requester 0
    input  logic [31:0] s0_awaddr,
    input  logic [3:0]  s0_awlen,
    input  logic [2:0]  s0_awsize,
    input  logic [1:0]  s0_awburst,
    input  logic        s0_awvalid,
    output logic        s0_awready,
    input  logic [63:0] s0_wdata,
    input  logic [7:0]  s0_wstrb,
    input  logic        s0_wlast,
    input  logic        s0_wvalid,
    output logic        s0_wready,
    output logic        s0_bvalid,
    output logic [1:0]  s0_bresp,
    input  logic        s0_bready,

    // requester 1
    input  logic [31:0] s1_awaddr,
    input  logic [3:0]  s1_awlen,
    input  logic [2:0]  s1_awsize,
    input  logic [1:0]  s1_awburst,
    input  logic        s1_awvalid,
    output logic        s1_awready,
    input  logic [63:0] s1_wdata,
    input  logic [7:0]  s1_wstrb,
    input  logic        s1_wlast,
    input  logic        s1_wvalid,
    output logic        s1_wready,
    output logic        s1_bvalid,
    output logic [1:0]  s1_bresp,
    input  logic        s1_bready,

    // shared HP port
    output logic [31:0] m_awaddr,
    output logic [3:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [63:0] m_wdata,
    output logic [7:0]  m_wstrb,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic        m_bvalid,
    input  logic [1:0]  m_bresp,
    output logic        m_bready,

    // status
    output logic [1:0]  grant_o,
    output logic        busy_o,
    output logic [1:0]  err_o,
    input  logic        clr_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  grant;
    logic        last_r;
    logic [1:0]  err_r;

    logic [1:0]  req;
    logic [1:0]  win;
    logic [1:0]  err_set;
    logic        sel1;
    logic        aw_hs;
    logic        w_done;
    logic        b_hs;

    // Winner for the next burst. last_r names the port that finished most recently.
    always_comb begin
        req = {s1_awvalid, s0_awvalid};
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = (RR_EN != 0 && !last_r) ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
    end

    assign sel1 = grant[1];

    // Route the owned channel between the granted requester and the HP port.
    // Everything else is forced to zero.
    always_comb begin
        m_awaddr   = '0;
        m_awlen    = '0;
        m_awsize   = '0;
        m_awburst  = '0;
        m_awvalid  = 1'b0;
        m_wdata    = '0;
        m_wstrb    = '0;
        m_wlast    = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        s0_awready = 1'b0;
        s1_awready = 1'b0;
        s0_wready  = 1'b0;
        s1_wready  = 1'b0;
        s0_bvalid  = 1'b0;
        s1_bvalid  = 1'b0;
        s0_bresp   = '0;
        s1_bresp   = '0;
        case (state)
            ST_ADDR: begin
                m_awaddr   = sel1 ? s1_awaddr  : s0_awaddr;
                m_awlen    = sel1 ? s1_awlen   : s0_awlen;
                m_awsize   = sel1 ? s1_awsize  : s0_awsize;
                m_awburst  = sel1 ? s1_awburst : s0_awburst;
                m_awvalid  = sel1 ? s1_awvalid : s0_awvalid;
                s0_awready = grant[0] & m_awready;
                s1_awready = grant[1] & m_awready;
            end
            ST_DATA: begin
                m_wdata   = sel1 ? s1_wdata  : s0_wdata;
                m_wstrb   = sel1 ? s1_wstrb  : s0_wstrb;
                m_wlast   = sel1 ? s1_wlast  : s0_wlast;
                m_wvalid  = sel1 ? s1_wvalid : s0_wvalid;
                s0_wready = grant[0] & m_wready;
                s1_wready = grant[1] & m_wready;
            end
            ST_RESP: begin
                m_bready  = sel1 ? s1_bready : s0_bready;
                s0_bvalid = grant[0] & m_bvalid;
                s1_bvalid = grant[1] & m_bvalid;
                s0_bresp  = grant[0] ? m_bresp : 2'b00;
                s1_bresp  = grant[1] ? m_bresp : 2'b00;
            end
            default: begin
            end
        endcase
    end

    // m_ valids and m_bready are already gated to their owning state above.
    // Data end follows wlast alone; beats are not counted against awlen.
    assign aw_hs   = m_awvalid & m_awready;
    assign w_done  = m_wvalid & m_wready & m_wlast;
    assign b_hs    = m_bvalid & m_bready;
    assign err_set = (b_hs && m_bresp != 2'b00) ? grant : 2'b00;

    // Burst ownership FSM. The grant is held from arbitration until the B handshake.
    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            grant  <= '0;
            last_r <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win != 2'b00) begin
                        grant <= win;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (aw_hs) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_done) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (b_hs) begin
                        state  <= ST_IDLE;
                        grant  <= '0;
                        last_r <= grant[1];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags. A new error outranks a clear in the same cycle.
    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) begin
            err_r <= '0;
        end else begin
            err_r <= (clr_err_i ? 2'b00 : err_r) | err_set;
        end
    end

    assign grant_o = grant;
    assign busy_o  = (state != ST_IDLE);
    assign err_o   = err_r;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_axi_wr_arbiter;

    localparam logic [31:0] A0  = 32'h4300_0000;
    localparam logic [31:0] A1  = 32'h5100_0040;
    localparam logic [3:0]  L0  = 4'd15;
    localparam logic [3:0]  L1  = 4'd3;
    localparam logic [2:0]  Z0  = 3'd3;
    localparam logic [2:0]  Z1  = 3'd2;
    localparam logic [1:0]  B0  = 2'd1;
    localparam logic [1:0]  B1  = 2'd0;
    localparam logic [63:0] WD0 = 64'hA0A0_1111_2222_0001;
    localparam logic [63:0] WD1 = 64'hB1B1_2222_3333_4444;
    localparam logic [7:0]  WS0 = 8'hFF;
    localparam logic [7:0]  WS1 = 8'h0F;

    logic aclk = 1'b0;
    logic rst_i;
    always #5 aclk = ~aclk;

    logic [31:0] s0_awaddr, s1_awaddr;
    logic [3:0]  s0_awlen, s1_awlen;
    logic [2:0]  s0_awsize, s1_awsize;
    logic [1:0]  s0_awburst, s1_awburst;
    logic        s0_awvalid, s1_awvalid;
    logic [63:0] s0_wdata, s1_wdata;
    logic [7:0]  s0_wstrb, s1_wstrb;
    logic        s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_bready, s1_bready;
    logic        m_awready, m_wready, m_bvalid, clr_err_i;
    logic [1:0]  m_bresp;

    logic        s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid;
    logic [1:0]  s0_bresp, s1_bresp;
    logic [31:0] m_awaddr;
    logic [3:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_awvalid, m_wlast, m_wvalid, m_bready, busy_o;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic [1:0]  grant_o, err_o;

    logic        fp_s0_awready, fp_s1_awready, fp_s0_wready, fp_s1_wready, fp_s0_bvalid, fp_s1_bvalid;
    logic [1:0]  fp_s0_bresp, fp_s1_bresp;
    logic [31:0] fp_m_awaddr;
    logic [3:0]  fp_m_awlen;
    logic [2:0]  fp_m_awsize;
    logic [1:0]  fp_m_awburst;
    logic        fp_m_awvalid, fp_m_wlast, fp_m_wvalid, fp_m_bready, fp_busy_o;
    logic [63:0] fp_m_wdata;
    logic [7:0]  fp_m_wstrb;
    logic [1:0]  fp_grant_o, fp_err_o;

    axi_wr_arbiter #(.RR_EN(1)) dut (
        .aclk(aclk), .rst_i(rst_i),
        .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize), .s0_awburst(s0_awburst),
        .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid),
        .s0_wready(s0_wready), .s0_bvalid(s0_bvalid), .s0_bresp(s0_bresp), .s0_bready(s0_bready),
        .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize), .s1_awburst(s1_awburst),
        .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid),
        .s1_wready(s1_wready), .s1_bvalid(s1_bvalid), .s1_bresp(s1_bresp), .s1_bready(s1_bready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o), .clr_err_i(clr_err_i)
    );

    axi_wr_arbiter #(.RR_EN(0)) dut_fp (
        .aclk(aclk), .rst_i(rst_i),
        .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize), .s0_awburst(s0_awburst),
        .s0_awvalid(s0_awvalid), .s0_awready(fp_s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid),
        .s0_wready(fp_s0_wready), .s0_bvalid(fp_s0_bvalid), .s0_bresp(fp_s0_bresp), .s0_bready(s0_bready),
        .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize), .s1_awburst(s1_awburst),
        .s1_awvalid(s1_awvalid), .s1_awready(fp_s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid),
        .s1_wready(fp_s1_wready), .s1_bvalid(fp_s1_bvalid), .s1_bresp(fp_s1_bresp), .s1_bready(s1_bready),
        .m_awaddr(fp_m_awaddr), .m_awlen(fp_m_awlen), .m_awsize(fp_m_awsize), .m_awburst(fp_m_awburst),
        .m_awvalid(fp_m_awvalid), .m_awready(m_awready),
        .m_wdata(fp_m_wdata), .m_wstrb(fp_m_wstrb), .m_wlast(fp_m_wlast), .m_wvalid(fp_m_wvalid),
        .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(fp_m_bready),
        .grant_o(fp_grant_o), .busy_o(fp_busy_o), .err_o(fp_err_o), .clr_err_i(clr_err_i)
    );

    // One cycle of stimulus plus the expected state (0 idle, 1 addr, 2 data, 3 resp),
    // grant and error flags for that cycle, all worked out by hand.
    typedef struct packed {
        logic       aw0, aw1, w0, w1, wl0, wl1, br0, br1, mawr, mwr, mbv;
        logic [1:0] mbresp;
        logic       clr;
        logic [1:0] st;
        logic [1:0] g;
        logic [1:0] err;
    } vec_t;

    vec_t tbl [22];
    int n_tests;
    int n_fail;

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [131:0] obs_rr();
        return {grant_o, busy_o, m_awvalid, m_wvalid, m_wlast, m_bready,
                s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid,
                s0_bresp, s1_bresp, err_o, m_awaddr, m_awlen, m_awsize, m_awburst,
                m_wdata, m_wstrb};
    endfunction

    function automatic logic [131:0] obs_fp();
        return {fp_grant_o, fp_busy_o, fp_m_awvalid, fp_m_wvalid, fp_m_wlast, fp_m_bready,
                fp_s0_awready, fp_s1_awready, fp_s0_wready, fp_s1_wready, fp_s0_bvalid, fp_s1_bvalid,
                fp_s0_bresp, fp_s1_bresp, fp_err_o, fp_m_awaddr, fp_m_awlen, fp_m_awsize, fp_m_awburst,
                fp_m_wdata, fp_m_wstrb};
    endfunction

    // Expected outputs for one table row: only the owning channel is routed, only to the granted port.
    function automatic logic [131:0] expect_row(input vec_t v);
        logic a, d, r, g0, g1;
        a  = (v.st == 2'd1);
        d  = (v.st == 2'd2);
        r  = (v.st == 2'd3);
        g0 = v.g[0];
        g1 = v.g[1];
        return {v.g, (v.st != 2'd0),
                a & (g1 ? v.aw1 : v.aw0), d & (g1 ? v.w1 : v.w0),
                d & (g1 ? v.wl1 : v.wl0), r & (g1 ? v.br1 : v.br0),
                a & g0 & v.mawr, a & g1 & v.mawr, d & g0 & v.mwr, d & g1 & v.mwr,
                r & g0 & v.mbv, r & g1 & v.mbv,
                (r & g0) ? v.mbresp : 2'b00, (r & g1) ? v.mbresp : 2'b00, v.err,
                a ? (g1 ? A1 : A0) : 32'h0, a ? (g1 ? L1 : L0) : 4'h0,
                a ? (g1 ? Z1 : Z0) : 3'h0, a ? (g1 ? B1 : B0) : 2'h0,
                d ? (g1 ? WD1 : WD0) : 64'h0, d ? (g1 ? WS1 : WS0) : 8'h0};
    endfunction

    function automatic logic [63:0] beat_data(input int k);
        return {32'hC0DE_0000 | 32'(k), 32'h5A5A_0000 + 32'(k)};
    endfunction

    task automatic clear_inputs();
        s0_awvalid = 0; s1_awvalid = 0; s0_wvalid = 0; s1_wvalid = 0;
        s0_wlast = 0; s1_wlast = 0; s0_bready = 0; s1_bready = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00; clr_err_i = 0;
        s0_wdata = WD0;
    endtask

    task automatic do_reset();
        rst_i = 1;
        clear_inputs();
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        rst_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got [16];
        int idx, cyc, n_acc, last_pos;
        logic [1:0] exp_g;

        n_tests = 0;
        n_fail  = 0;
        //        aw0 aw1 w0 w1 wl0 wl1 br0 br1 mawr mwr mbv mbresp clr  st    g      err
        tbl = '{
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'd0, 2'b00, 2'b00},
            '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'd0, 2'b00, 2'b00},
            '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'd1, 2'b01, 2'b00},
            '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'd1, 2'b01, 2'b00},
            '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'd1, 2'b01, 2'b00},
            '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'd2, 2'b01, 2'b00},
            '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'd2, 2'b01, 2'b00},
            '{0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'd2, 2'b01, 2'b00},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'd3, 2'b01, 2'b00},
            '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 0, 2'd3, 2'b01, 2'b00},
            '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'd0, 2'b00, 2'b00},
            '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'd1, 2'b10, 2'b00},
            '{0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 2'b00, 0, 2'd2, 2'b10, 2'b00},
            '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2'b10, 0, 2'd3, 2'b10, 2'b00},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'd0, 2'b00, 2'b10},
            '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'd0, 2'b00, 2'b10},
            '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'd1, 2'b01, 2'b10},
            '{0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'd2, 2'b01, 2'b10},
            '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b10, 1, 2'd3, 2'b01, 2'b10},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'd0, 2'b00, 2'b01},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'd0, 2'b00, 2'b01},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'd0, 2'b00, 2'b00}
        };

        s0_awaddr = A0; s0_awlen = L0; s0_awsize = Z0; s0_awburst = B0; s0_wstrb = WS0;
        s1_awaddr = A1; s1_awlen = L1; s1_awsize = Z1; s1_awburst = B1; s1_wstrb = WS1;
        s1_wdata  = WD1;
        clear_inputs();

        // Reset state, with requests and slave readiness already present.
        rst_i = 1;
        s0_awvalid = 1; s1_awvalid = 1; m_awready = 1; m_wready = 1; m_bvalid = 1;
        #12;
        chk("reset_rr", obs_rr(), 132'(0));
        @(posedge aclk); #1;
        chk("reset_fp", obs_fp(), 132'(0));
        do_reset();

        // Per-cycle vector table.
        for (int i = 0; i < 22; i++) begin
            s0_awvalid = tbl[i].aw0;  s1_awvalid = tbl[i].aw1;
            s0_wvalid  = tbl[i].w0;   s1_wvalid  = tbl[i].w1;
            s0_wlast   = tbl[i].wl0;  s1_wlast   = tbl[i].wl1;
            s0_bready  = tbl[i].br0;  s1_bready  = tbl[i].br1;
            m_awready  = tbl[i].mawr; m_wready   = tbl[i].mwr;
            m_bvalid   = tbl[i].mbv;  m_bresp    = tbl[i].mbresp;
            clr_err_i  = tbl[i].clr;
            #1;
            chk($sformatf("vec%0d", i), obs_rr(), expect_row(tbl[i]));
            @(posedge aclk); #1;
        end

        // 16-beat s0 burst: AW stalled 5 cycles, then wready toggling every cycle.
        do_reset();
        s1_wvalid = 1;
        s0_awvalid = 1;
        #1;
        chk("aw_latency_c0", 132'(m_awvalid), 132'(0));
        @(posedge aclk); #1;
        chk("aw_latency_c1", 132'({grant_o, m_awvalid, m_awaddr, m_awlen}), 132'({2'b01, 1'b1, A0, L0}));
        for (int i = 0; i < 4; i++) begin
            @(posedge aclk); #1;
            chk($sformatf("aw_stall%0d", i), 132'({m_awvalid, s0_awready, busy_o}), 132'({1'b1, 1'b0, 1'b1}));
        end
        @(posedge aclk); #1;
        m_awready = 1;
        #1;
        chk("aw_accept", 132'({s0_awready, s1_awready}), 132'(2'b10));
        @(posedge aclk); #1;
        s0_awvalid = 0;
        m_awready  = 0;
        idx = 0; cyc = 0; n_acc = 0; last_pos = -1;
        while (idx < 16 && cyc < 64) begin
            s0_wvalid = 1;
            s0_wdata  = beat_data(idx);
            s0_wlast  = (idx == 15);
            m_wready  = cyc[0];
            #1;
            chk($sformatf("bp_wdata_c%0d", cyc), 132'({m_wvalid, m_wdata, s0_wready, s1_wready}),
                132'({1'b1, beat_data(idx), m_wready, 1'b0}));
            if (m_wvalid && m_wready) begin
                if (n_acc < 16) got[n_acc] = m_wdata;
                if (m_wlast) last_pos = n_acc;
                n_acc++;
            end
            if (m_wready) idx++;
            @(posedge aclk); #1;
            cyc++;
        end
        s0_wvalid = 0; s0_wlast = 0; m_wready = 0; s1_wvalid = 0;
        chk("bp_beat_count", 132'(n_acc), 132'(16));
        chk("bp_wlast_pos", 132'(last_pos), 132'(15));
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("bp_beat%0d", k), 132'(got[k]), 132'(beat_data(k)));
        end
        m_bvalid = 1; s0_bready = 1;
        #1;
        chk("single_resp", 132'({grant_o, s0_bvalid, s1_bvalid, m_bready}), 132'({2'b01, 1'b1, 1'b0, 1'b1}));
        @(posedge aclk); #1;
        m_bvalid = 0; s0_bready = 0;
        #1;
        chk("single_done", 132'({grant_o, busy_o, err_o}), 132'(0));

        // Continuous contention: RR alternates, fixed priority always takes port 0.
        do_reset();
        s0_awvalid = 1; s1_awvalid = 1; s0_wvalid = 1; s1_wvalid = 1;
        s0_wlast = 1; s1_wlast = 1; s0_bready = 1; s1_bready = 1;
        m_awready = 1; m_wready = 1; m_bvalid = 1;
        #1;
        chk("cont_idle_start", 132'({grant_o, busy_o}), 132'(0));
        for (int b = 0; b < 4; b++) begin
            exp_g = (b % 2 == 0) ? 2'b01 : 2'b10;
            for (int c = 0; c < 3; c++) begin
                @(posedge aclk); #1;
                chk($sformatf("rr_b%0d_c%0d", b, c), 132'(grant_o), 132'(exp_g));
                chk($sformatf("fp_b%0d_c%0d", b, c), 132'({fp_grant_o, fp_s1_awready}), 132'({2'b01, 1'b0}));
                if (c == 0) begin
                    chk($sformatf("rr_addr_b%0d", b), 132'(m_awaddr), 132'((b % 2 == 0) ? A0 : A1));
                end
            end
            @(posedge aclk); #1;
            chk($sformatf("rr_gap_b%0d", b), 132'({grant_o, busy_o, fp_grant_o, fp_s1_awready}), 132'(0));
        end

        // Reset arriving on beat 7 of a burst, then a fresh s1 request.
        do_reset();
        s0_awvalid = 1; m_awready = 1; m_wready = 1;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        s0_awvalid = 0;
        s0_wvalid  = 1;
        s0_wlast   = 0;
        for (int k = 0; k < 7; k++) begin
            s0_wdata = beat_data(k);
            @(posedge aclk); #1;
        end
        s0_wdata = beat_data(7);
        #1;
        chk("midrst_beat7", 132'({m_wvalid, m_wdata, grant_o}), 132'({1'b1, beat_data(7), 2'b01}));
        rst_i = 1;
        #1;
        chk("midrst_outputs", obs_rr(), 132'(0));
        @(posedge aclk); #1;
        rst_i = 0;
        clear_inputs();
        s1_awvalid = 1;
        #1;
        chk("post_rst_idle", 132'({grant_o, busy_o}), 132'(0));
        @(posedge aclk); #1;
        chk("post_rst_grant", 132'({grant_o, m_awvalid, m_awaddr}), 132'({2'b10, 1'b1, A1}));
        m_awready = 1;
        #1;
        chk("post_rst_awready", 132'({s0_awready, s1_awready}), 132'(2'b01));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with port 0 winning.
REQ-002 Port aclk, input, 1 bit: clock for all logic.
REQ-003 Port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-004 Ports sN_awaddr/awlen/awsize/awburst, input, 32/4/3/2 bits, N in {0,1}: AXI3 write-address payload from requester N.
REQ-005 Port sN_awvalid, input, 1 bit, and sN_awready, output, 1 bit: AW handshake for requester N.
REQ-006 Ports sN_wdata/wstrb/wlast/wvalid, input, 64/8/1/1 bits, and sN_wready, output, 1 bit: W channel for requester N.
REQ-007 Ports sN_bvalid/bresp, output, 1/2 bits, and sN_bready, input, 1 bit: B channel for requester N.
REQ-008 Ports m_awaddr/awlen/awsize/awburst/awvalid, output, 32/4/3/2/1 bits, and m_awready, input, 1 bit: AW channel to the shared HP port.
REQ-009 Ports m_wdata/wstrb/wlast/wvalid, output, 64/8/1/1 bits, and m_wready, input, 1 bit: W channel to the HP port.
REQ-010 Ports m_bvalid/bresp, input, 1/2 bits, and m_bready, output, 1 bit: B channel from the HP port.
REQ-011 Port grant_o, output, 2 bits: one-hot owner of the current burst, 00 when idle.
REQ-012 Port busy_o, output, 1 bit: high in any state other than ST_IDLE.
REQ-013 Port err_o, output, 2 bits: sticky per-port flag for a non-OKAY bresp.
REQ-014 Port clr_err_i, input, 1 bit: clears err_o.

Function
REQ-015 States SHALL be ST_IDLE, ST_ADDR, ST_DATA and ST_RESP, and exactly one burst SHALL be owned from its AW handshake through its B handshake.
REQ-016 In ST_IDLE, if any sN_awvalid is high, the arbiter SHALL register the winner into grant and move to ST_ADDR on the next edge; otherwise it stays in ST_IDLE.
REQ-017 Winner selection: a single request wins; with both requesting, RR_EN=1 grants the port that is not last_r, and RR_EN=0 grants port 0.
REQ-018 last_r SHALL update to the granted port only on B handshake completion.
REQ-019 In ST_ADDR: m_aw* = granted sN_aw*; sN_awready = m_awready for the granted port only; on m_awvalid & m_awready go to ST_DATA.
REQ-020 In ST_DATA: m_w* = granted sN_w*; granted sN_wready = m_wready; on m_wvalid & m_wready & m_wlast go to ST_RESP.
REQ-021 In ST_RESP: granted sN_bvalid/bresp = m_bvalid/bresp; m_bready = granted sN_bready; on m_bvalid & m_bready go to ST_IDLE and clear grant.
REQ-022 The non-granted port SHALL see awready = wready = bvalid = 0 and bresp = 00 in every state.
REQ-023 Outside its owning state, each m_ valid/ready output SHALL be 0 and each m_ payload output SHALL be 0.
REQ-024 Payload and handshake paths SHALL be combinational with 0 cycles of added latency; the grant decision SHALL cost exactly 1 cycle.
REQ-025 Every burst SHALL be followed by at least 1 ST_IDLE cycle; completion and a new request in the same cycle SHALL NOT regrant in that cycle.
REQ-026 A sN_awvalid deasserted while waiting in ST_ADDR SHALL NOT release the grant, because AXI forbids withdrawing a valid.
REQ-027 On B handshake with bresp != 00, err_o[granted] SHALL set; clr_err_i SHALL clear both bits; a set and a clear in the same cycle SHALL leave the bit set.
REQ-028 A wlast earlier than awlen+1 beats SHALL still be honored as end of data; beats SHALL NOT be counted.

Reset
REQ-029 Asserting rst_i SHALL immediately force: state ST_IDLE, grant 00, last_r = 1 (port 0 wins first), err_o 00, busy_o 0, and all valid/ready outputs 0.
REQ-030 Reset mid-burst SHALL abort ownership with no completion; rst_i SHALL be applied to the HP port at the same time.
REQ-031 After rst_i is released, the first arbitration SHALL occur on the first aclk edge at which any awvalid is high.

Verification
REQ-032 Single requester: s0 issues awaddr 0x4300_0000, awlen 15, 16 beats, bresp 00 -> m_awvalid rises 1 cycle after s0_awvalid, all 16 beats pass unmodified, grant_o 01 through the B handshake, then 00.
REQ-033 Contention with RR_EN=1: s0 and s1 request simultaneously and repeatedly for 4 bursts -> grants alternate 01, 10, 01, 10, with exactly 1 idle cycle between bursts.
REQ-034 Fixed priority with RR_EN=0: both request continuously for 3 bursts -> all 3 bursts granted to s0, and s1_awready stays 0.
REQ-035 Backpressure: m_awready is held low 5 cycles, then m_wready toggles every cycle -> no beat is lost or duplicated, and the non-granted port sees wready 0.
REQ-036 Error path: the slave returns bresp 10 on s1's burst, then clr_err_i pulses in the same cycle as a new error on s0 -> err_o goes 10, then 01.
REQ-037 Reset mid-operation: rst_i asserts on beat 7 of a burst -> all outputs are at reset values before the next edge, and a subsequent s1 request is granted normally.
